// File: rtl/avr_cpu_fetch.sv
// AVR instruction fetch / PC unit: drives the 1-cycle synchronous program-memory port and feeds
// opcode/opcode_cycle to the decoder; RJMP completes in two cycles with no bubble. Optional macro: AVR_CPU_FETCH_STALL_EN.
module avr_cpu_fetch #(
    parameter int PC_WIDTH = 10
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] pm_addr,
    input  logic [15:0]         pm_data,
    output logic [15:0]         opcode,
    output logic                opcode_cycle,
    input  logic                hold,
    input  logic [11:0]         rjmp,
`ifdef AVR_CPU_FETCH_STALL_EN
    input  logic                stall,
`endif
    output logic [PC_WIDTH-1:0] pc
);

    localparam int EXT_W = (PC_WIDTH > 12) ? PC_WIDTH : 12;
    localparam logic [PC_WIDTH-1:0] PC_ONE = 1;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        JUMP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         op_lat_q, op_lat_d;

    logic                stall_act;
    logic [EXT_W-1:0]    rjmp_ext;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] jmp_target;

`ifdef AVR_CPU_FETCH_STALL_EN
    assign stall_act = stall;
`else
    assign stall_act = 1'b0;
`endif

    // Sign-extend to at least PC_WIDTH, then wrap modulo 2^PC_WIDTH.
    assign rjmp_ext   = EXT_W'(signed'(rjmp));
    assign pc_inc     = pc_q + PC_ONE;
    assign jmp_target = pc_inc + rjmp_ext[PC_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        op_lat_d     = op_lat_q;
        pm_addr      = pc_q;
        opcode       = 16'h0000;
        opcode_cycle = 1'b0;

        case (state_q)
            FILL: begin
                state_d = RUN;
            end
            RUN: begin
                opcode = pm_data;
                if (hold) begin
                    pm_addr  = jmp_target;
                    pc_d     = jmp_target;
                    op_lat_d = pm_data;
                    state_d  = JUMP;
                end else begin
                    pm_addr = pc_inc;
                    pc_d    = pc_inc;
                end
            end
            JUMP: begin
                opcode       = op_lat_q;
                opcode_cycle = 1'b1;
                state_d      = RUN;
            end
            default: begin
                state_d = FILL;
            end
        endcase

        // Re-reading pc_q keeps pm_data aligned with the frozen instruction.
        if (stall_act) begin
            state_d  = state_q;
            pc_d     = pc_q;
            op_lat_d = op_lat_q;
            pm_addr  = pc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            pc_q     <= '0;
            op_lat_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            op_lat_q <= op_lat_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: tb/tb_avr_cpu_fetch.sv
// Directed bench for avr_cpu_fetch with a 1-cycle synchronous program memory model.
module tb_avr_cpu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  pm_addr;
    logic [15:0] pm_data;
    logic [15:0] opcode;
    logic        opcode_cycle;
    logic        hold;
    logic [11:0] rjmp;
    logic [9:0]  pc;
`ifdef AVR_CPU_FETCH_STALL_EN
    logic        stall;
`endif

    logic [15:0] mem [0:1023];
    int checks = 0;
    int errors = 0;

    avr_cpu_fetch #(.PC_WIDTH(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .pm_addr      (pm_addr),
        .pm_data      (pm_data),
        .opcode       (opcode),
        .opcode_cycle (opcode_cycle),
        .hold         (hold),
        .rjmp         (rjmp),
`ifdef AVR_CPU_FETCH_STALL_EN
        .stall        (stall),
`endif
        .pc           (pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) pm_data <= mem[pm_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_out(input string tag, input logic [15:0] op, input logic cyc,
                           input logic [9:0] pcv, input logic [9:0] addr);
        chk({tag, ".opcode"}, 32'(opcode), 32'(op));
        chk({tag, ".opcode_cycle"}, 32'(opcode_cycle), 32'(cyc));
        chk({tag, ".pc"}, 32'(pc), 32'(pcv));
        chk({tag, ".pm_addr"}, 32'(pm_addr), 32'(addr));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic h, input logic [11:0] k);
        hold = h;
        rjmp = k;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'hE000 | 16'(i);
        mem[3] = 16'hC004;
        rst  = 1'b1;
        hold = 1'b0;
        rjmp = 12'h000;
`ifdef AVR_CPU_FETCH_STALL_EN
        stall = 1'b0;
`endif
        tick();
        tick();
        drive(1'b1, 12'h000);
        chk_out("reset", 16'h0000, 1'b0, 10'd0, 10'd0);

        rst = 1'b0;
        drive(1'b1, 12'h7FF);
        chk_out("fill", 16'h0000, 1'b0, 10'd0, 10'd0);

        // Straight-line issue
        tick(); drive(1'b0, 12'h000);
        chk_out("run0", 16'hE000, 1'b0, 10'd0, 10'd1);
        tick(); drive(1'b0, 12'h000);
        chk_out("run1", 16'hE001, 1'b0, 10'd1, 10'd2);
        tick(); drive(1'b0, 12'h000);
        chk_out("run2", 16'hE002, 1'b0, 10'd2, 10'd3);

        // Forward RJMP at pc=3, k=+4 -> target 8
        tick(); drive(1'b1, 12'h004);
        chk_out("fwd_req", 16'hC004, 1'b0, 10'd3, 10'd8);
        tick(); drive(1'b0, 12'h000);
        chk_out("fwd_jump", 16'hC004, 1'b1, 10'd8, 10'd8);
        tick(); drive(1'b1, 12'hFFC);
        chk_out("fwd_tgt", 16'hE008, 1'b0, 10'd8, 10'd5);

        // k=-4 from pc=8 lands on 5, then RJMP to self
        tick(); drive(1'b0, 12'h000);
        chk_out("back_jump", 16'hE008, 1'b1, 10'd5, 10'd5);
        tick(); drive(1'b1, 12'hFFF);
        chk_out("self_req", 16'hE005, 1'b0, 10'd5, 10'd5);
        tick(); drive(1'b1, 12'h3AA);
        chk_out("self_jump", 16'hE005, 1'b1, 10'd5, 10'd5);
        tick(); drive(1'b1, 12'hFFF);
        chk_out("self_run2", 16'hE005, 1'b0, 10'd5, 10'd5);
        tick(); drive(1'b0, 12'h000);
        chk_out("self_jump2", 16'hE005, 1'b1, 10'd5, 10'd5);

        // Jump to 16 then reset during the JUMP cycle
        tick(); drive(1'b1, 12'h00A);
        chk_out("pre_rst_req", 16'hE005, 1'b0, 10'd5, 10'd16);
        tick(); drive(1'b0, 12'h000);
        chk_out("pre_rst_jump", 16'hE005, 1'b1, 10'd16, 10'd16);
        rst = 1'b1;
        tick(); rst = 1'b0; drive(1'b0, 12'h000);
        chk_out("midjump_rst", 16'h0000, 1'b0, 10'd0, 10'd0);
        tick(); drive(1'b1, 12'h3FB);
        chk_out("after_rst", 16'hE000, 1'b0, 10'd0, 10'd1020);

        // Upper wrap: 1020 + 1 + 5 -> 2
        tick(); drive(1'b0, 12'h000);
        chk_out("to1020_jump", 16'hE000, 1'b1, 10'd1020, 10'd1020);
        tick(); drive(1'b1, 12'h005);
        chk_out("wrap_req", 16'hE3FC, 1'b0, 10'd1020, 10'd2);
        tick(); drive(1'b0, 12'h000);
        chk_out("wrap_jump", 16'hE3FC, 1'b1, 10'd2, 10'd2);
        tick(); drive(1'b1, 12'h3FC);
        chk_out("wrap_tgt", 16'hE002, 1'b0, 10'd2, 10'd1023);
        tick(); drive(1'b0, 12'h000);
        chk_out("to1023_jump", 16'hE002, 1'b1, 10'd1023, 10'd1023);

        // Increment 1023 -> 0
        tick(); drive(1'b0, 12'h000);
        chk_out("inc_wrap", 16'hE3FF, 1'b0, 10'd1023, 10'd0);
        tick(); drive(1'b1, 12'hFFE);
        chk_out("pc0_again", 16'hE000, 1'b0, 10'd0, 10'd1023);

        // Lower wrap: 0 + 1 - 2 -> 1023
        tick(); drive(1'b0, 12'h000);
        chk_out("low_wrap_jump", 16'hE000, 1'b1, 10'd1023, 10'd1023);
        tick(); drive(1'b0, 12'h000);
        chk_out("low_wrap_tgt", 16'hE3FF, 1'b0, 10'd1023, 10'd0);
        tick(); drive(1'b0, 12'h000);
        chk_out("seq0", 16'hE000, 1'b0, 10'd0, 10'd1);
        tick(); drive(1'b0, 12'h000);
        chk_out("seq1", 16'hE001, 1'b0, 10'd1, 10'd2);
        tick(); drive(1'b0, 12'h000);
        chk_out("seq2", 16'hE002, 1'b0, 10'd2, 10'd3);
        tick(); drive(1'b0, 12'h000);
        chk_out("seq3", 16'hC004, 1'b0, 10'd3, 10'd4);
        tick(); drive(1'b0, 12'h000);
        chk_out("seq4", 16'hE004, 1'b0, 10'd4, 10'd5);

`ifdef AVR_CPU_FETCH_STALL_EN
        stall = 1'b1;
        drive(1'b0, 12'h000);
        chk_out("stall_c0", 16'hE004, 1'b0, 10'd4, 10'd4);
        tick(); drive(1'b0, 12'h000);
        chk_out("stall_c1", 16'hE004, 1'b0, 10'd4, 10'd4);
        tick(); drive(1'b0, 12'h000);
        chk_out("stall_c2", 16'hE004, 1'b0, 10'd4, 10'd4);
        stall = 1'b0;
        drive(1'b0, 12'h000);
        chk_out("stall_rel", 16'hE004, 1'b0, 10'd4, 10'd5);
        tick(); stall = 1'b1; drive(1'b1, 12'h002);
        chk_out("stall_hold", 16'hE005, 1'b0, 10'd5, 10'd5);
        tick(); drive(1'b1, 12'h002);
        chk_out("stall_hold2", 16'hE005, 1'b0, 10'd5, 10'd5);
        stall = 1'b0;
        drive(1'b1, 12'h002);
        chk_out("deferred_req", 16'hE005, 1'b0, 10'd5, 10'd8);
        tick(); drive(1'b0, 12'h000);
        chk_out("deferred_jump", 16'hE005, 1'b1, 10'd8, 10'd8);
        tick(); drive(1'b0, 12'h000);
        chk_out("deferred_tgt", 16'hE008, 1'b0, 10'd8, 10'd9);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
